// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants, FSM encoding and helpers for the writeback port arbiter.
package wb_port_arbiter_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   localparam int CNT_W      = 4;

   localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

   typedef enum logic {
      SHARE = 1'b0,
      FORCE = 1'b1
   } wb_state_e;

   // One-hot mask for a register address; x0 never produces a bit.
   function automatic logic [NUM_REGS-1:0] rd_mask(input logic [REG_ADDR_W-1:0] rd);
      rd_mask = '0;
      if (rd != ZERO_REG) rd_mask[rd] = 1'b1;
   endfunction

endpackage

// File: rtl/wb_port_arbiter_scoreboard.sv
// Busy-bit scoreboard of registers with mul/div results still outstanding.
module wb_scoreboard
   import wb_port_arbiter_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  set_en,
   input  logic [REG_ADDR_W-1:0] set_rd,
   input  logic                  clr_en,
   input  logic [REG_ADDR_W-1:0] clr_rd,
   output logic [NUM_REGS-1:0]   busy
);

   logic [NUM_REGS-1:0] set_mask;
   logic [NUM_REGS-1:0] clr_mask;
   logic [NUM_REGS-1:0] busy_next;

   // Set is applied after clear so a same-cycle issue to a retiring register keeps it busy.
   always_comb begin
      set_mask     = set_en ? rd_mask(set_rd) : '0;
      clr_mask     = clr_en ? rd_mask(clr_rd) : '0;
      busy_next    = (busy & ~clr_mask) | set_mask;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) busy <= '0;
      else       busy <= busy_next;
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter between pipeline writeback (P) and mul/div (M),
// with a busy scoreboard and a starvation guard that forces a pipeline bubble.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int XLEN         = 64,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  p_valid,
   input  logic [REG_ADDR_W-1:0] p_rd,
   input  logic [XLEN-1:0]       p_data,
   input  logic                  m_valid,
   output logic                  m_ready,
   input  logic [REG_ADDR_W-1:0] m_rd,
   input  logic [XLEN-1:0]       m_data,
   input  logic                  sb_set,
   input  logic [REG_ADDR_W-1:0] sb_rd,
   output logic [NUM_REGS-1:0]   busy,
   output logic                  stall_wb,
   output logic                  wr_en,
   output logic [REG_ADDR_W-1:0] wr_rd,
   output logic [XLEN-1:0]       wr_data
);

   localparam logic [CNT_W:0] LIMIT = (CNT_W+1)'(STARVE_LIMIT);

   wb_state_e             state, state_next;
   logic [CNT_W-1:0]      cnt, cnt_next;
   logic [CNT_W:0]        cnt_inc;
   logic                  grant_any;
   logic [REG_ADDR_W-1:0] g_rd;
   logic [XLEN-1:0]       g_data;

   // P always wins; a forced bubble works only because the pipeline honours stall_wb.
   always_comb begin
      m_ready   = ~reset & ~p_valid & m_valid;
      grant_any = p_valid | m_ready;
      g_rd      = p_valid ? p_rd   : m_rd;
      g_data    = p_valid ? p_data : m_data;
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      cnt_inc    = {1'b0, cnt} + 1'b1;
      case (state)
         SHARE: begin
            if (!m_valid || m_ready) begin
               cnt_next = '0;
            end else if (cnt_inc >= LIMIT) begin
               state_next = FORCE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_inc[CNT_W-1:0];
            end
         end
         FORCE: begin
            cnt_next = '0;
            if (m_ready || !m_valid) state_next = SHARE;
         end
         default: begin
            state_next = SHARE;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= SHARE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   assign stall_wb = (state == FORCE);

   // rd/data follow the winner even for x0; only wr_en is suppressed.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_en   <= 1'b0;
         wr_rd   <= ZERO_REG;
         wr_data <= '0;
      end else if (grant_any) begin
         wr_en   <= (g_rd != ZERO_REG);
         wr_rd   <= g_rd;
         wr_data <= g_data;
      end else begin
         wr_en   <= 1'b0;
      end
   end

   wb_scoreboard u_sb (
      .clk    (clk),
      .reset  (reset),
      .set_en (sb_set),
      .set_rd (sb_rd),
      .clr_en (m_valid & m_ready),
      .clr_rd (m_rd),
      .busy   (busy)
   );

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed table-driven bench for wb_port_arbiter plus starvation/reset sequences.
module tb_wb_port_arbiter;

   localparam int XLEN = 64;
   localparam int LIM  = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            p_valid, m_valid, m_ready, sb_set;
   logic [4:0]      p_rd, m_rd, sb_rd, wr_rd;
   logic [XLEN-1:0] p_data, m_data, wr_data;
   logic [31:0]     busy;
   logic            stall_wb, wr_en;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   wb_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .reset(reset),
      .p_valid(p_valid), .p_rd(p_rd), .p_data(p_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_rd(m_rd), .m_data(m_data),
      .sb_set(sb_set), .sb_rd(sb_rd),
      .busy(busy), .stall_wb(stall_wb),
      .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data)
   );

   typedef struct {
      logic        pv;  logic [4:0] prd; logic [63:0] pd;
      logic        mv;  logic [4:0] mrd; logic [63:0] md;
      logic        ss;  logic [4:0] srd;
      logic        e_mr; logic e_en; logic [4:0] e_rd; logic [63:0] e_data;
      logic [31:0] e_busy; logic e_stall;
   } vec_t;

   vec_t tbl[14];

   function automatic vec_t mk(
      input logic pv, input logic [4:0] prd, input logic [63:0] pd,
      input logic mv, input logic [4:0] mrd, input logic [63:0] md,
      input logic ss, input logic [4:0] srd,
      input logic e_mr, input logic e_en, input logic [4:0] e_rd,
      input logic [63:0] e_data, input logic [31:0] e_busy, input logic e_stall);
      vec_t v;
      v.pv = pv; v.prd = prd; v.pd = pd; v.mv = mv; v.mrd = mrd; v.md = md;
      v.ss = ss; v.srd = srd; v.e_mr = e_mr; v.e_en = e_en; v.e_rd = e_rd;
      v.e_data = e_data; v.e_busy = e_busy; v.e_stall = e_stall;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic drive(input logic pv, input logic [4:0] prd, input logic [63:0] pd,
                        input logic mv, input logic [4:0] mrd, input logic [63:0] md,
                        input logic ss, input logic [4:0] srd);
      p_valid = pv; p_rd = prd; p_data = pd;
      m_valid = mv; m_rd = mrd; m_data = md;
      sb_set = ss; sb_rd = srd;
   endtask

   task automatic edge_wait();
      @(posedge clk);
      #1;
   endtask

   // Holds P and M both valid; M must be refused LIM cycles, then stall_wb rises.
   task automatic starve(input logic [4:0] mrd, input logic [63:0] md);
      drive(1'b1, 5'd1, 64'h10, 1'b1, mrd, md, 1'b0, 5'd0);
      for (int k = 0; k < LIM; k++) begin
         #1;
         chk("starve_m_ready", m_ready, 0);
         chk("starve_stall_lo", stall_wb, 0);
         edge_wait();
      end
      chk("starve_stall_hi", stall_wb, 1);
      drive(1'b0, 5'd0, 64'h0, 1'b1, mrd, md, 1'b0, 5'd0);
   endtask

   initial begin
      // Reset: M requesting, but m_ready must stay low.
      reset = 1'b1;
      drive(1'b0, 5'd0, 64'h0, 1'b1, 5'd3, 64'h5, 1'b0, 5'd0);
      edge_wait();
      edge_wait();
      chk("rst_m_ready", m_ready, 0);
      chk("rst_wr_en",   wr_en,   0);
      chk("rst_wr_rd",   wr_rd,   0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_busy",    busy,    0);
      chk("rst_stall",   stall_wb, 0);
      reset = 1'b0;

      //           pv prd  pd       mv mrd md        ss srd | mr en rd  data     busy      stall
      tbl[0]  = mk(1, 5, 64'hAA,   0, 0, 64'h0,    0, 0,    0, 1, 5, 64'hAA,   32'h0,   0);
      tbl[1]  = mk(1, 6, 64'hBB,   1, 3, 64'h55,   0, 0,    0, 1, 6, 64'hBB,   32'h0,   0);
      tbl[2]  = mk(0, 0, 64'h0,    0, 0, 64'h0,    1, 7,    0, 0, 6, 64'hBB,   32'h80,  0);
      tbl[3]  = mk(0, 0, 64'h0,    1, 7, 64'h1234, 0, 0,    1, 1, 7, 64'h1234, 32'h0,   0);
      tbl[4]  = mk(0, 0, 64'h0,    0, 0, 64'h0,    1, 9,    0, 0, 7, 64'h1234, 32'h200, 0);
      tbl[5]  = mk(0, 0, 64'h0,    1, 9, 64'h99,   1, 9,    1, 1, 9, 64'h99,   32'h200, 0);
      tbl[6]  = mk(0, 0, 64'h0,    1, 9, 64'h77,   0, 0,    1, 1, 9, 64'h77,   32'h0,   0);
      tbl[7]  = mk(0, 0, 64'h0,    0, 0, 64'h0,    1, 0,    0, 0, 9, 64'h77,   32'h0,   0);
      tbl[8]  = mk(0, 0, 64'h0,    0, 0, 64'h0,    1, 4,    0, 0, 9, 64'h77,   32'h10,  0);
      tbl[9]  = mk(0, 0, 64'h0,    1, 0, 64'hDEAD, 0, 0,    1, 0, 0, 64'hDEAD, 32'h10,  0);
      tbl[10] = mk(1, 0, 64'h11,   0, 0, 64'h0,    0, 0,    0, 0, 0, 64'h11,   32'h10,  0);
      tbl[11] = mk(1, 4, 64'h44,   0, 0, 64'h0,    0, 0,    0, 1, 4, 64'h44,   32'h10,  0);
      tbl[12] = mk(1, 2, 64'h22,   1, 4, 64'h4444, 0, 0,    0, 1, 2, 64'h22,   32'h10,  0);
      tbl[13] = mk(0, 0, 64'h0,    1, 4, 64'h4444, 0, 0,    1, 1, 4, 64'h4444, 32'h0,   0);

      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].pv, tbl[i].prd, tbl[i].pd, tbl[i].mv, tbl[i].mrd, tbl[i].md,
               tbl[i].ss, tbl[i].srd);
         #1;
         chk("vec_m_ready", m_ready, tbl[i].e_mr);
         chk("vec_protocol", p_valid & stall_wb, 0);
         edge_wait();
         chk("vec_wr_en",   wr_en,    tbl[i].e_en);
         chk("vec_wr_rd",   wr_rd,    tbl[i].e_rd);
         chk("vec_wr_data", wr_data,  tbl[i].e_data);
         chk("vec_busy",    busy,     tbl[i].e_busy);
         chk("vec_stall",   stall_wb, tbl[i].e_stall);
      end

      // Starvation: forced bubble grants M, then P resumes next cycle.
      starve(5'd3, 64'h33);
      #1;
      chk("force_m_ready", m_ready, 1);
      edge_wait();
      chk("force_exit_stall", stall_wb, 0);
      chk("force_wr_en",   wr_en,   1);
      chk("force_wr_rd",   wr_rd,   3);
      chk("force_wr_data", wr_data, 64'h33);
      drive(1'b1, 5'd8, 64'h88, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
      #1;
      chk("resume_m_ready", m_ready, 0);
      edge_wait();
      chk("resume_wr_en", wr_en, 1);
      chk("resume_wr_rd", wr_rd, 8);

      // m_valid dropping inside FORCE returns to SHARE.
      starve(5'd3, 64'h33);
      drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
      edge_wait();
      chk("mdrop_stall", stall_wb, 0);
      chk("mdrop_wr_en", wr_en, 0);

      // Reset while in FORCE with x7 busy.
      drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd7);
      edge_wait();
      chk("pre_busy", busy, 32'h80);
      starve(5'd3, 64'h33);
      chk("force_busy", busy, 32'h80);
      reset = 1'b1;
      #1;
      chk("rst_force_m_ready", m_ready, 0);
      edge_wait();
      reset = 1'b0;
      chk("rst_force_busy",  busy,     0);
      chk("rst_force_stall", stall_wb, 0);
      chk("rst_force_wr_en", wr_en,    0);
      // Counter must restart from zero after reset: full LIM refusals again.
      starve(5'd3, 64'h33);
      drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
      edge_wait();
      chk("final_stall", stall_wb, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the register file's single write port between the in-order pipeline writeback (requester P) and the long-latency mul/div unit (requester M).
- Keeps a busy-bit scoreboard of destination registers with M results outstanding, so hazard detection can stall dependent instructions.
- Drives the register-file write inputs from registered outputs.
- Prevents M starvation by forcing a one-cycle pipeline writeback bubble.

Parameters:
- XLEN, 64, data width of write data.
- STARVE_LIMIT, 4, consecutive cycles M may be refused before a forced bubble (legal range 1..15).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- p_valid  input  1  pipeline writeback valid; never back-pressured.
- p_rd  input  5  pipeline destination register.
- p_data  input  XLEN  pipeline writeback data.
- m_valid  input  1  mul/div result valid.
- m_ready  output  1  mul/div result accepted this cycle (combinational).
- m_rd  input  5  mul/div destination register.
- m_data  input  XLEN  mul/div result data.
- sb_set  input  1  mul/div instruction issued this cycle.
- sb_rd  input  5  destination register of the issued mul/div.
- busy  output  32  scoreboard; bit i set means an M result for xi is outstanding.
- stall_wb  output  1  registered; the pipeline must present p_valid=0 in any cycle where this is 1.
- wr_en  output  1  to register file reg_write.
- wr_rd  output  5  to register file rd.
- wr_data  output  XLEN  to register file write_data.

Behaviour:
- Reset state: wr_en=0, wr_rd=0, wr_data=0, busy=0, stall_wb=0, starve counter=0, FSM in SHARE. m_ready is 0 during reset. Reset mid-operation discards any in-flight grant and clears the scoreboard.
- Grant rule, combinational in the current cycle:
  - p_valid=1: P wins; m_ready=0.
  - Otherwise: m_ready = m_valid.
  - p_valid=1 while stall_wb=1 is a protocol violation. The bench flags it as an error; the RTL still grants P.
- Write output, 1-cycle latency, registered from the winner:
  - wr_en = (granted request exists) AND (granted rd != 0).
  - wr_rd and wr_data capture the winner's rd and data.
  - With no grant, wr_en=0 and wr_rd/wr_data hold their previous values.
  - A grant with rd=0 completes its handshake normally but produces wr_en=0.
- Scoreboard update, per cycle:
  - Clear busy[m_rd] when m_valid&&m_ready.
  - Set busy[sb_rd] when sb_set=1 and sb_rd!=0.
  - Same register set and cleared in the same cycle: set wins.
  - busy[0] is always 0.
  - A P write never changes busy.
- Starvation FSM, two states:
  - SHARE:
    - Counter increments each cycle m_valid=1 && m_ready=0 (saturating at STARVE_LIMIT).
    - Counter clears when m_valid=0 or when M is granted.
    - When the counter reaches STARVE_LIMIT, go to FORCE next cycle with stall_wb=1.
  - FORCE:
    - stall_wb=1; M is granted by the grant rule because p_valid=0.
    - On the M grant, return to SHARE next cycle with stall_wb=0 and counter=0.
    - If m_valid drops while in FORCE, return to SHARE next cycle.
- Starvation timing: with p_valid held at 1 and m_valid held at 1, M is refused for exactly STARVE_LIMIT cycles, stall_wb rises in the next cycle, and M is granted in that cycle.
- Pipeline stall boundary: after a stall_wb cycle, p_valid may resume the following cycle.
- No internal buffering: M must hold m_valid, m_rd and m_data stable until m_ready.

Decomposition:
- Shared package holds:
  - REG_ADDR_W=5 and NUM_REGS=32.
  - The FSM state encoding SHARE/FORCE.
  - Constant ZERO_REG=5'd0.
- One natural sub-module, wb_scoreboard: the 32-bit busy vector with set/clear ports and the set-wins and x0 rules.
- The arbiter, starvation FSM and output registers stay in the top module.

Test Plan:
- Reset, then p_valid=1, p_rd=5, p_data=0xAA -> next cycle wr_en=1, wr_rd=5, wr_data=0xAA; m_ready=0 throughout.
- sb_set=1, sb_rd=7 -> busy[7]=1 next cycle; then m_valid=1, m_rd=7, m_data=0x1234 with p_valid=0 -> m_ready=1 same cycle; next cycle wr_en=1, wr_rd=7, wr_data=0x1234, busy[7]=0.
- Same-cycle set and clear on x9 (sb_set sb_rd=9 with an M grant on m_rd=9) -> busy[9] stays 1. sb_set with sb_rd=0 -> busy stays all-zero.
- STARVE_LIMIT=4, p_valid and m_valid both held at 1 from cycle 0:
  - m_ready=0 in cycles 0-3.
  - stall_wb=1 in cycle 4; the bench drops p_valid, m_ready=1 in cycle 4.
  - stall_wb=0 in cycle 5.
- M grant with m_rd=0 -> m_ready=1, next cycle wr_en=0, busy unchanged.
- Assert reset for one cycle while in FORCE with busy=0x0000_0080 -> next cycle busy=0, stall_wb=0, wr_en=0, FSM in SHARE.
